// File: rtl/hc_csr_pkg.sv
// Shared types, address map and decode helpers for the HardCloud MMIO CSR block.
// The CCI-P MMIO channel structs are reduced to the fields this block uses.
package hc_csr_pkg;

    localparam logic [17:0] HC_ADDR_WIN_BASE = 18'h100;
    localparam logic [17:0] HC_ADDR_STATUS   = 18'h108;
    localparam logic [17:0] HC_ADDR_DSM_BASE = 18'h110;
    localparam logic [17:0] HC_ADDR_CONTROL  = 18'h118;
    localparam logic [17:0] HC_ADDR_BUF_BASE = 18'h120;
    localparam logic [17:0] HC_BUF_STRIDE    = 18'h10;

    localparam logic [63:0] HC_CONTROL_ASSERT_RST   = 64'd0;
    localparam logic [63:0] HC_CONTROL_DEASSERT_RST = 64'd1;
    localparam logic [63:0] HC_CONTROL_START        = 64'd3;
    localparam logic [63:0] HC_CONTROL_STOP         = 64'd7;

    localparam logic [1:0] HC_LEN_4B = 2'b00;
    localparam logic [1:0] HC_LEN_8B = 2'b01;

    typedef logic [63:0] t_hc_address;

    typedef struct packed {
        t_hc_address address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_STOP  = 3'd4
    } t_hc_ctl_state;

    typedef struct packed {
        logic [15:0] address;   // 4-byte word address
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioWrValid;
        logic                mmioRdValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    function automatic logic window_hit(input logic [17:0] byte_addr, input int num_buffers);
        return (byte_addr >= HC_ADDR_WIN_BASE) &&
               (byte_addr < HC_ADDR_BUF_BASE + 18'(num_buffers) * HC_BUF_STRIDE);
    endfunction

    function automatic logic [3:0] buf_index(input logic [17:0] byte_addr);
        return 4'((byte_addr - HC_ADDR_BUF_BASE) >> 4);
    endfunction

    function automatic logic is_size(input logic [17:0] byte_addr);
        return (byte_addr & 18'h8) != 18'h0;
    endfunction

    // 4B writes carry their payload in data[31:0] whichever half they target.
    function automatic logic [63:0] merge_write(input logic [63:0] old, input logic [63:0] data,
                                                input logic [1:0] length, input logic hi_word);
        if (length == HC_LEN_8B) return data;
        if (hi_word)             return {data[31:0], old[31:0]};
        return {old[63:32], data[31:0]};
    endfunction

endpackage

// File: rtl/hc_ctl_fsm.sv
// Control FSM for the CSR block: decodes CONTROL writes into state moves,
// the one-cycle start pulse and the done/error sticky flags.
module hc_ctl_fsm
    import hc_csr_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ctl_wr,
    input  logic [63:0]   ctl_code,
    input  logic          all_valid,
    input  logic          acc_done,
    output t_hc_ctl_state state,
    output logic          start,
    output logic          done_sticky,
    output logic          err_sticky,
    output logic          clr_valid
);

    t_hc_ctl_state state_q, state_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every variable gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        clr_valid = 1'b0;
        if (ctl_wr) begin
            // A CONTROL write masks acc_done for this cycle.
            unique case (ctl_code)
                HC_CONTROL_ASSERT_RST: begin
                    state_d   = S_RESET;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    clr_valid = 1'b1;
                end
                HC_CONTROL_DEASSERT_RST: begin
                    if (state_q == S_RESET) state_d = S_IDLE;
                end
                HC_CONTROL_START: begin
                    if (state_q inside {S_IDLE, S_DONE, S_STOP} && all_valid) begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                HC_CONTROL_STOP: begin
                    if (state_q == S_RUN) state_d = S_STOP;
                end
                default: err_d = 1'b1;
            endcase
        end else if (state_q == S_RUN && acc_done) begin
            state_d = S_DONE;
            done_d  = 1'b1;
        end
    end

    assign state       = state_q;
    assign start       = start_q;
    assign done_sticky = done_q;
    assign err_sticky  = err_q;

endmodule

// File: rtl/hc_mmio_csr.sv
// HardCloud AFU CSR block: MMIO register file for DSM base, CONTROL and
// NUM_BUFFERS descriptors, registered c2 read responses, control FSM instance.
module hc_mmio_csr
    import hc_csr_pkg::*;
#(
    parameter int NUM_BUFFERS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  t_if_ccip_c0_Rx               rx_mmio,
    output t_if_ccip_c2_Tx               tx_mmio,
    input  logic                         acc_done,
    output t_hc_address                  dsm_base,
    output t_hc_buffer [NUM_BUFFERS-1:0] buffers,
    output logic                         soft_rst,
    output logic                         start,
    output t_hc_ctl_state                ctl_state
);

    logic [17:0]      byte_addr, reg_addr;
    logic             hit, hi_word, wr_en, ctl_wr;
    logic             sel_status, sel_dsm, sel_ctl, sel_buf, sel_size;
    logic [3:0]       buf_idx;
    logic [63:0]      ctl_code, rd_data;
    logic             done_sticky, err_sticky, clr_valid;
    logic             rd_valid_q;
    logic [8:0]       rd_tid_q;
    logic [63:0]      rd_data_q, control_q;
    t_hc_address      dsm_base_q;
    t_hc_buffer [NUM_BUFFERS-1:0] buf_q;
    logic [NUM_BUFFERS-1:0]       addr_seen_q, size_seen_q, desc_valid;
    logic             unused_rsvd;

    assign unused_rsvd = rx_mmio.hdr.rsvd;

    always_comb begin
        byte_addr  = {rx_mmio.hdr.address, 2'b00};
        reg_addr   = byte_addr & ~18'h7;
        hi_word    = rx_mmio.hdr.address[0];
        hit        = window_hit(byte_addr, NUM_BUFFERS);
        sel_status = hit && (reg_addr == HC_ADDR_STATUS);
        sel_dsm    = hit && (reg_addr == HC_ADDR_DSM_BASE);
        sel_ctl    = hit && (reg_addr == HC_ADDR_CONTROL);
        sel_buf    = hit && (reg_addr >= HC_ADDR_BUF_BASE);
        sel_size   = is_size(byte_addr);
        buf_idx    = buf_index(byte_addr);
        wr_en      = rx_mmio.mmioWrValid &&
                     (rx_mmio.hdr.length == HC_LEN_4B || rx_mmio.hdr.length == HC_LEN_8B);
        ctl_wr     = wr_en && sel_ctl;
        ctl_code   = merge_write(control_q, rx_mmio.data, rx_mmio.hdr.length, hi_word);
    end

    // NOTE: the descriptor array is tiny and must read back zero after reset, so it is reset like any flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsm_base_q  <= '0;
            control_q   <= '0;
            buf_q       <= '0;
            addr_seen_q <= '0;
            size_seen_q <= '0;
        end else begin
            if (clr_valid) begin
                addr_seen_q <= '0;
                size_seen_q <= '0;
            end
            if (wr_en && sel_dsm) dsm_base_q <= merge_write(dsm_base_q, rx_mmio.data, rx_mmio.hdr.length, hi_word);
            if (ctl_wr)           control_q  <= ctl_code;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (wr_en && sel_buf && buf_idx == 4'(i)) begin
                    if (sel_size) begin
                        buf_q[i].size  <= 32'(merge_write({32'b0, buf_q[i].size}, rx_mmio.data,
                                                          rx_mmio.hdr.length, hi_word));
                        size_seen_q[i] <= 1'b1;
                    end else begin
                        buf_q[i].address <= merge_write(buf_q[i].address, rx_mmio.data,
                                                        rx_mmio.hdr.length, hi_word);
                        addr_seen_q[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign desc_valid = addr_seen_q & size_seen_q;

    hc_ctl_fsm u_ctl_fsm (
        .clk         (clk),
        .reset       (reset),
        .ctl_wr      (ctl_wr),
        .ctl_code    (ctl_code),
        .all_valid   (&desc_valid),
        .acc_done    (acc_done),
        .state       (ctl_state),
        .start       (start),
        .done_sticky (done_sticky),
        .err_sticky  (err_sticky),
        .clr_valid   (clr_valid)
    );

    always_comb begin
        rd_data = '0;
        if (sel_status) begin
            rd_data[2:0]  = ctl_state;
            rd_data[3]    = done_sticky;
            rd_data[4]    = err_sticky;
            rd_data[23:8] = 16'(desc_valid);
        end
        if (sel_dsm) rd_data = dsm_base_q;
        if (sel_ctl) rd_data = control_q;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (sel_buf && buf_idx == 4'(i))
                rd_data = sel_size ? {32'b0, buf_q[i].size} : buf_q[i].address;
        end
    end

    // Out-of-window reads are left for the AFU top to answer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_tid_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rx_mmio.mmioRdValid && hit;
            if (rx_mmio.mmioRdValid && hit) begin
                rd_tid_q  <= rx_mmio.hdr.tid;
                rd_data_q <= rd_data;
            end
        end
    end

    always_comb begin
        tx_mmio             = '0;
        tx_mmio.hdr.tid     = rd_tid_q;
        tx_mmio.mmioRdValid = rd_valid_q;
        tx_mmio.data        = rd_data_q;
    end

    assign dsm_base = dsm_base_q;
    assign buffers  = buf_q;
    assign soft_rst = (ctl_state == S_RESET);

endmodule

// File: tb/tb_hc_mmio_csr.sv
// Directed bench for hc_mmio_csr: NUM_BUFFERS=4 primary instance plus 1 and 16
// instances sharing the same MMIO stimulus for window-size regression.
module tb_hc_mmio_csr;
    import hc_csr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic acc_done = 1'b0;
    t_if_ccip_c0_Rx rx;
    t_if_ccip_c2_Tx tx4, tx1, tx16;
    t_hc_address dsm4, dsm1, dsm16;
    t_hc_buffer [3:0]  buf4;
    t_hc_buffer [0:0]  buf1;
    t_hc_buffer [15:0] buf16;
    logic srst4, srst1, srst16, st4, st1, st16;
    t_hc_ctl_state cs4, cs1, cs16;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hc_mmio_csr #(.NUM_BUFFERS(4)) dut4 (
        .clk(clk), .reset(reset), .rx_mmio(rx), .tx_mmio(tx4), .acc_done(acc_done),
        .dsm_base(dsm4), .buffers(buf4), .soft_rst(srst4), .start(st4), .ctl_state(cs4));
    hc_mmio_csr #(.NUM_BUFFERS(1)) dut1 (
        .clk(clk), .reset(reset), .rx_mmio(rx), .tx_mmio(tx1), .acc_done(acc_done),
        .dsm_base(dsm1), .buffers(buf1), .soft_rst(srst1), .start(st1), .ctl_state(cs1));
    hc_mmio_csr #(.NUM_BUFFERS(16)) dut16 (
        .clk(clk), .reset(reset), .rx_mmio(rx), .tx_mmio(tx16), .acc_done(acc_done),
        .dsm_base(dsm16), .buffers(buf16), .soft_rst(srst16), .start(st16), .ctl_state(cs16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_write(input logic [17:0] a, input logic [63:0] d, input logic is8);
        rx = '0;
        rx.hdr.address = a[17:2];
        rx.hdr.length  = is8 ? HC_LEN_8B : HC_LEN_4B;
        rx.data        = d;
        rx.mmioWrValid = 1'b1;
    endtask

    task automatic mmio_write(input logic [17:0] a, input logic [63:0] d, input logic is8);
        @(negedge clk);
        set_write(a, d, is8);
        @(negedge clk);
        rx = '0;
    endtask

    task automatic mmio_read(input logic [17:0] a, input logic [8:0] tid);
        @(negedge clk);
        rx = '0;
        rx.hdr.address = a[17:2];
        rx.hdr.length  = HC_LEN_8B;
        rx.hdr.tid     = tid;
        rx.mmioRdValid = 1'b1;
        @(negedge clk);
        rx = '0;
    endtask

    task automatic read_check(input string tag, input logic [17:0] a, input logic [8:0] tid,
                              input logic [63:0] exp);
        mmio_read(a, tid);
        check({tag, " rd_valid"}, 64'(tx4.mmioRdValid), 64'd1);
        check({tag, " tid"}, 64'(tx4.hdr.tid), 64'(tid));
        check({tag, " data"}, tx4.data, exp);
        @(negedge clk);
        check({tag, " rd_valid drop"}, 64'(tx4.mmioRdValid), 64'd0);
    endtask

    initial begin
        rx = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset state", 64'(cs4), 64'(S_RESET));
        check("reset soft_rst", 64'(srst4), 64'd1);
        check("reset start", 64'(st4), 64'd0);
        check("reset tx valid", 64'(tx4.mmioRdValid), 64'd0);
        check("reset dsm_base", dsm4, 64'd0);
        read_check("status after reset", 18'h108, 9'h1A5, 64'd0);

        mmio_write(18'h120, 64'hDEAD_BEEF_0000_1000, 1'b1);
        mmio_write(18'h128, 64'h40, 1'b0);
        check("buf0 address", buf4[0].address, 64'hDEAD_BEEF_0000_1000);
        check("buf0 size", 64'(buf4[0].size), 64'h40);
        read_check("buf0 addr readback", 18'h120, 9'h011, 64'hDEAD_BEEF_0000_1000);
        read_check("buf0 size readback", 18'h128, 9'h012, 64'h40);

        mmio_write(18'h118, HC_CONTROL_DEASSERT_RST, 1'b1);
        check("deassert state", 64'(cs4), 64'(S_IDLE));
        check("deassert soft_rst", 64'(srst4), 64'd0);

        mmio_write(18'h130, 64'h2000, 1'b0);
        mmio_write(18'h134, 64'h1, 1'b0);
        mmio_write(18'h138, 64'h100, 1'b1);
        mmio_write(18'h140, 64'h5000, 1'b1);
        mmio_write(18'h148, 64'h200, 1'b0);
        check("buf1 split address", buf4[1].address, 64'h1_0000_2000);

        mmio_write(18'h118, HC_CONTROL_START, 1'b1);
        check("start invalid state", 64'(cs4), 64'(S_IDLE));
        check("start invalid pulse", 64'(st4), 64'd0);
        check("n1 start state", 64'(cs1), 64'(S_RUN));
        check("n1 start pulse", 64'(st1), 64'd1);
        check("n16 start invalid state", 64'(cs16), 64'(S_IDLE));
        read_check("status err mask7", 18'h108, 9'h020, 64'h711);

        mmio_write(18'h150, 64'h3000, 1'b1);
        mmio_write(18'h158, 64'h80, 1'b0);
        mmio_write(18'h118, HC_CONTROL_START, 1'b1);
        check("start state", 64'(cs4), 64'(S_RUN));
        check("start pulse", 64'(st4), 64'd1);
        @(negedge clk);
        check("start pulse width", 64'(st4), 64'd0);

        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        check("done state", 64'(cs4), 64'(S_DONE));
        read_check("status done", 18'h108, 9'h021, 64'hF1B);

        mmio_write(18'h118, HC_CONTROL_START, 1'b1);
        check("restart state", 64'(cs4), 64'(S_RUN));
        check("restart pulse", 64'(st4), 64'd1);
        read_check("status restart", 18'h108, 9'h022, 64'hF12);

        @(negedge clk);
        set_write(18'h118, HC_CONTROL_STOP, 1'b1);
        acc_done = 1'b1;
        @(negedge clk);
        rx = '0;
        acc_done = 1'b0;
        check("stop beats done", 64'(cs4), 64'(S_STOP));
        read_check("status stop", 18'h108, 9'h023, 64'hF14);

        mmio_read(18'h300, 9'h030);
        check("far read no response", 64'(tx4.mmioRdValid), 64'd0);
        mmio_read(18'h160, 9'h031);
        check("just past top no response", 64'(tx4.mmioRdValid), 64'd0);
        read_check("top high word", 18'h15C, 9'h032, 64'h80);
        read_check("hole 0x100", 18'h100, 9'h033, 64'd0);
        mmio_read(18'h218, 9'h034);
        check("n16 top responds", 64'(tx16.mmioRdValid), 64'd1);
        check("n16 top tid", 64'(tx16.hdr.tid), 64'h034);
        check("n4 beyond window", 64'(tx4.mmioRdValid), 64'd0);
        mmio_read(18'h130, 9'h035);
        check("n1 beyond window", 64'(tx1.mmioRdValid), 64'd0);
        check("n4 buf1 readback", tx4.data, 64'h1_0000_2000);

        mmio_write(18'h118, HC_CONTROL_ASSERT_RST, 1'b1);
        check("assert_rst state", 64'(cs4), 64'(S_RESET));
        check("assert_rst soft_rst", 64'(srst4), 64'd1);
        check("assert_rst keeps buf0", buf4[0].address, 64'hDEAD_BEEF_0000_1000);
        check("assert_rst keeps buf3 size", 64'(buf4[3].size), 64'h80);
        read_check("status cleared", 18'h108, 9'h040, 64'd0);

        mmio_write(18'h118, 64'h5, 1'b1);
        check("bad code state", 64'(cs4), 64'(S_RESET));
        read_check("status bad code", 18'h108, 9'h041, 64'h10);
        read_check("control readback", 18'h118, 9'h042, 64'h5);

        mmio_write(18'h108, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        read_check("status write ignored", 18'h108, 9'h043, 64'h10);

        mmio_write(18'h110, 64'h0000_0001_2345_6780, 1'b1);
        mmio_write(18'h114, 64'hCAFE, 1'b0);
        check("dsm_base high word", dsm4, 64'h0000_CAFE_2345_6780);
        read_check("dsm readback", 18'h110, 9'h044, 64'h0000_CAFE_2345_6780);

        @(negedge clk);
        rx.hdr.address = 16'h0044;
        rx.hdr.length  = HC_LEN_8B;
        rx.hdr.tid     = 9'h050;
        rx.mmioRdValid = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset drops read", 64'(tx4.mmioRdValid), 64'd0);
        check("reset clears dsm", dsm4, 64'd0);
        check("reset clears buf0", buf4[0].address, 64'd0);
        check("reset state again", 64'(cs4), 64'(S_RESET));
        @(negedge clk);
        rx = '0;
        reset = 1'b0;
        @(negedge clk);
        check("no late response", 64'(tx4.mmioRdValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
